onchip_ram_dp: RTL and testbench

//  Parametrised true-dual-port Avalon-MM on-chip RAM for the Nios system fabric.
//  Two independent slaves (s1, s2) share one byte-enabled array.

---
 rtl/onchip_ram_pkg.sv | 14 +
 rtl/onchip_ram_dp_if.sv | 30 +++
 rtl/onchip_ram_core.sv | 50 +++++
 rtl/onchip_ram_dp.sv | 190 +++++++++++++++++++
 tb/tb_onchip_ram_dp.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/onchip_ram_pkg.sv
// Shared types, constants and helpers for the true-dual-port on-chip RAM.
package onchip_ram_pkg;

    typedef enum logic [1:0] {RST, CLEAR, READY} state_e;

    localparam int unsigned DATA_W_DEFAULT = 32;
    localparam int unsigned BE_W           = DATA_W_DEFAULT / 8;
    localparam int unsigned MAX_LATENCY    = 2;

    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/onchip_ram_dp_if.sv
// Avalon-MM slave bundle for one port of the dual-port RAM.
interface onchip_ram_dp_if
    import onchip_ram_pkg::*;
#(
    parameter int unsigned DATA_W = BE_W * 8,
    parameter int unsigned ADDR_W = 13
) ();
    localparam int unsigned BYTES = DATA_W / 8;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              read;
    logic              write;
    logic [BYTES-1:0]  byteenable;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;
    logic              waitrequest;

    modport master (
        output address, chipselect, read, write, byteenable, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, chipselect, read, write, byteenable, writedata,
        output readdata, readdatavalid, waitrequest
    );

endinterface

// File: rtl/onchip_ram_core.sv
// Two-port byte-enabled array with one registered read per port, shaped for block RAM.
module onchip_ram_core #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned IDX_W  = 4
) (
    input  logic                  clk,
    input  logic                  ce,
    input  logic                  a_we,
    input  logic [DATA_W/8-1:0]   a_be,
    input  logic [IDX_W-1:0]      a_addr,
    input  logic [DATA_W-1:0]     a_wdata,
    input  logic                  a_re,
    output logic [DATA_W-1:0]     a_rdata,
    input  logic                  b_we,
    input  logic [DATA_W/8-1:0]   b_be,
    input  logic [IDX_W-1:0]      b_addr,
    input  logic [DATA_W-1:0]     b_wdata,
    input  logic                  b_re,
    output logic [DATA_W-1:0]     b_rdata
);
    localparam int unsigned BYTES = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

    // Reads sample the array before this edge's writes: old data on collisions.
    always_comb begin
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        if (ce && a_re) a_rdata_d = mem[a_addr];
        if (ce && b_re) b_rdata_d = mem[b_addr];
    end

    always_ff @(posedge clk) begin
        a_rdata_q <= a_rdata_d;
        b_rdata_q <= b_rdata_d;
        if (ce) begin
            for (int i = 0; i < BYTES; i++) begin
                if (b_we && b_be[i]) mem[b_addr][i*8 +: 8] <= b_wdata[i*8 +: 8];
                if (a_we && a_be[i]) mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
            end
        end
    end

    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;

endmodule

// File: rtl/onchip_ram_dp.sv
// True-dual-port Avalon-MM on-chip RAM: clear sweep FSM, range guard, collision
// resolution and per-port read-valid pipelines around a two-port array.
module onchip_ram_dp
    import onchip_ram_pkg::*;
#(
    parameter int unsigned DATA_W         = DATA_W_DEFAULT,
    parameter int unsigned ADDR_W         = 13,
    parameter int unsigned DEPTH          = 5120,
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           reset_req,
    input  logic           clken,
    onchip_ram_dp_if.slave s1,
    onchip_ram_dp_if.slave s2,
    output logic           init_done
);
    localparam int unsigned      BYTES     = DATA_W / 8;
    localparam int unsigned      IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
    localparam bit               TWO_STAGE = (READ_LATENCY >= MAX_LATENCY);

    logic   en;
    logic   wait_req;
    state_e state_q, state_d;
    logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;

    logic [ADDR_W-1:0] p_addr  [2];
    logic              p_cs    [2];
    logic              p_rd    [2];
    logic              p_wr    [2];
    logic [BYTES-1:0]  p_be    [2];
    logic [DATA_W-1:0] p_wdata [2];
    logic              rd_acc  [2];
    logic              wr_acc  [2];
    logic              in_rng  [2];

    logic              a_we, a_re, b_we, b_re;
    logic [BYTES-1:0]  a_be, b_be;
    logic [IDX_W-1:0]  a_addr, b_addr;
    logic [DATA_W-1:0] a_wdata, b_wdata;
    logic [DATA_W-1:0] core_rdata [2];

    logic              v1_q [2], v1_d [2];
    logic              rng1_q [2], rng1_d [2];
    logic              v2_q [2], v2_d [2];
    logic [DATA_W-1:0] data2_q [2], data2_d [2];
    logic [DATA_W-1:0] stage1_data [2];
    logic [DATA_W-1:0] rdata [2];
    logic              rvalid [2];

    assign en        = clken & ~reset_req;
    assign wait_req  = (state_q != READY) | ~en;
    assign init_done = (state_q == READY);

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (en) begin
            case (state_q)
                RST: begin
                    clr_cnt_d = '0;
                    state_d   = (CLEAR_ON_RESET != 0) ? CLEAR : READY;
                end
                CLEAR: begin
                    if (clr_cnt_q == LAST_IDX) begin
                        clr_cnt_d = '0;
                        state_d   = READY;
                    end else begin
                        clr_cnt_d = clr_cnt_q + 1'b1;
                    end
                end
                READY:   state_d = READY;
                default: state_d = RST;
            endcase
        end
    end

    always_comb begin
        p_addr[0] = s1.address;  p_cs[0] = s1.chipselect; p_rd[0] = s1.read;
        p_wr[0]   = s1.write;    p_be[0] = s1.byteenable; p_wdata[0] = s1.writedata;
        p_addr[1] = s2.address;  p_cs[1] = s2.chipselect; p_rd[1] = s2.read;
        p_wr[1]   = s2.write;    p_be[1] = s2.byteenable; p_wdata[1] = s2.writedata;
        for (int p = 0; p < 2; p++) begin
            // A simultaneous read and write on one port performs only the write.
            wr_acc[p] = p_cs[p] & p_wr[p] & ~wait_req;
            rd_acc[p] = p_cs[p] & p_rd[p] & ~p_wr[p] & ~wait_req;
            in_rng[p] = addr_in_range(32'(p_addr[p]), DEPTH);
        end
    end

    always_comb begin
        a_we    = wr_acc[0] & in_rng[0];
        a_re    = rd_acc[0] & in_rng[0];
        a_be    = p_be[0];
        a_addr  = p_addr[0][IDX_W-1:0];
        a_wdata = p_wdata[0];
        if (state_q == CLEAR) begin
            a_we    = 1'b1;
            a_re    = 1'b0;
            a_be    = '1;
            a_addr  = clr_cnt_q;
            a_wdata = '0;
        end
        b_we    = wr_acc[1] & in_rng[1];
        b_re    = rd_acc[1] & in_rng[1];
        b_be    = p_be[1];
        b_addr  = p_addr[1][IDX_W-1:0];
        b_wdata = p_wdata[1];
        // Same-word double write: s1 owns every byte it enables.
        if (a_we && b_we && (a_addr == b_addr)) b_be = p_be[1] & ~a_be;
    end

    onchip_ram_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_core (
        .clk     (clk),
        .ce      (en),
        .a_we    (a_we),
        .a_be    (a_be),
        .a_addr  (a_addr),
        .a_wdata (a_wdata),
        .a_re    (a_re),
        .a_rdata (core_rdata[0]),
        .b_we    (b_we),
        .b_be    (b_be),
        .b_addr  (b_addr),
        .b_wdata (b_wdata),
        .b_re    (b_re),
        .b_rdata (core_rdata[1])
    );

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            stage1_data[p] = rng1_q[p] ? core_rdata[p] : '0;
            v1_d[p]        = v1_q[p];
            rng1_d[p]      = rng1_q[p];
            v2_d[p]        = v2_q[p];
            data2_d[p]     = data2_q[p];
            if (en) begin
                v1_d[p] = rd_acc[p];
                if (rd_acc[p]) rng1_d[p] = in_rng[p];
                v2_d[p] = v1_q[p];
                if (v1_q[p]) data2_d[p] = stage1_data[p];
            end
            // Strobes are gated by en so a stalled valid bit is never seen twice.
            if (TWO_STAGE) begin
                rvalid[p] = v2_q[p] & en;
                rdata[p]  = data2_q[p];
            end else begin
                rvalid[p] = v1_q[p] & en;
                rdata[p]  = v1_q[p] ? stage1_data[p] : '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RST;
            clr_cnt_q <= '0;
            for (int p = 0; p < 2; p++) begin
                v1_q[p]    <= 1'b0;
                rng1_q[p]  <= 1'b0;
                v2_q[p]    <= 1'b0;
                data2_q[p] <= '0;
            end
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            for (int p = 0; p < 2; p++) begin
                v1_q[p]    <= v1_d[p];
                rng1_q[p]  <= rng1_d[p];
                v2_q[p]    <= v2_d[p];
                data2_q[p] <= data2_d[p];
            end
        end
    end

    assign s1.readdata      = rdata[0];
    assign s1.readdatavalid = rvalid[0];
    assign s1.waitrequest   = wait_req;
    assign s2.readdata      = rdata[1];
    assign s2.readdatavalid = rvalid[1];
    assign s2.waitrequest   = wait_req;

endmodule

// File: tb/tb_onchip_ram_dp.sv
// Bench for onchip_ram_dp: latency-1 and latency-2 instances share one stimulus stream
// and are checked against a word-array model with a per-port schedule of read results.
module tb_onchip_ram_dp;
    localparam int unsigned DEPTH = 16;

    logic clk = 1'b0;
    logic reset;
    logic reset_req_r;
    logic clken_r;
    always #5 clk = ~clk;

    logic [12:0] addr_v [2];
    logic        cs_v   [2];
    logic        rd_v   [2];
    logic        wr_v   [2];
    logic [3:0]  be_v   [2];
    logic [31:0] wd_v   [2];

    logic [31:0] o_rdata [4];
    logic        o_valid [4];
    logic        o_wait  [4];
    logic        o_done  [2];

    onchip_ram_dp_if #(.DATA_W(32), .ADDR_W(13)) if_a1 ();
    onchip_ram_dp_if #(.DATA_W(32), .ADDR_W(13)) if_a2 ();
    onchip_ram_dp_if #(.DATA_W(32), .ADDR_W(13)) if_b1 ();
    onchip_ram_dp_if #(.DATA_W(32), .ADDR_W(13)) if_b2 ();

    assign if_a1.address = addr_v[0]; assign if_b1.address = addr_v[0];
    assign if_a1.chipselect = cs_v[0]; assign if_b1.chipselect = cs_v[0];
    assign if_a1.read = rd_v[0]; assign if_b1.read = rd_v[0];
    assign if_a1.write = wr_v[0]; assign if_b1.write = wr_v[0];
    assign if_a1.byteenable = be_v[0]; assign if_b1.byteenable = be_v[0];
    assign if_a1.writedata = wd_v[0]; assign if_b1.writedata = wd_v[0];
    assign if_a2.address = addr_v[1]; assign if_b2.address = addr_v[1];
    assign if_a2.chipselect = cs_v[1]; assign if_b2.chipselect = cs_v[1];
    assign if_a2.read = rd_v[1]; assign if_b2.read = rd_v[1];
    assign if_a2.write = wr_v[1]; assign if_b2.write = wr_v[1];
    assign if_a2.byteenable = be_v[1]; assign if_b2.byteenable = be_v[1];
    assign if_a2.writedata = wd_v[1]; assign if_b2.writedata = wd_v[1];

    assign o_rdata[0] = if_a1.readdata; assign o_valid[0] = if_a1.readdatavalid;
    assign o_rdata[1] = if_a2.readdata; assign o_valid[1] = if_a2.readdatavalid;
    assign o_rdata[2] = if_b1.readdata; assign o_valid[2] = if_b1.readdatavalid;
    assign o_rdata[3] = if_b2.readdata; assign o_valid[3] = if_b2.readdatavalid;
    assign o_wait[0] = if_a1.waitrequest; assign o_wait[1] = if_a2.waitrequest;
    assign o_wait[2] = if_b1.waitrequest; assign o_wait[3] = if_b2.waitrequest;

    onchip_ram_dp #(
        .DATA_W(32), .ADDR_W(13), .DEPTH(DEPTH), .READ_LATENCY(1), .CLEAR_ON_RESET(1)
    ) dut_l1 (
        .clk(clk), .reset(reset), .reset_req(reset_req_r), .clken(clken_r),
        .s1(if_a1), .s2(if_a2), .init_done(o_done[0])
    );

    onchip_ram_dp #(
        .DATA_W(32), .ADDR_W(13), .DEPTH(DEPTH), .READ_LATENCY(2), .CLEAR_ON_RESET(1)
    ) dut_l2 (
        .clk(clk), .reset(reset), .reset_req(reset_req_r), .clken(clken_r),
        .s1(if_b1), .s2(if_b2), .init_done(o_done[1])
    );

    int checks = 0;
    int errors = 0;

    // Model state: memory words, en-cycle counters, scheduled read results per dut/port.
    logic [31:0] mem_m [DEPTH];
    int          en_since = 0;
    int          en_idx   = 0;
    logic [31:0] rb_data [4][8];
    int          rb_due  [4][8];
    int          rb_head [4];
    int          rb_cnt  [4];

    task automatic check(input string tag, input int idx, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] observed=%h expected=%h", tag, idx, obs, exp);
        end
    endtask

    task automatic push(input int k, input logic [31:0] d, input int due);
        int t;
        t = (rb_head[k] + rb_cnt[k]) % 8;
        rb_data[k][t] = d;
        rb_due[k][t]  = due;
        rb_cnt[k]++;
    endtask

    task automatic model_accept();
        logic [31:0] rdv [2];
        bit          rdq [2];
        int          a;
        for (int p = 0; p < 2; p++) begin
            rdq[p] = 1'b0;
            rdv[p] = '0;
            a = int'(addr_v[p]);
            if (cs_v[p] && rd_v[p] && !wr_v[p]) begin
                rdq[p] = 1'b1;
                if (a < DEPTH) rdv[p] = mem_m[a];
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (rdq[p]) begin
                push(p, rdv[p], en_idx + 1);
                push(2 + p, rdv[p], en_idx + 2);
            end
        end
        // s2 applied before s1 so s1 owns overlapping bytes.
        for (int p = 1; p >= 0; p--) begin
            a = int'(addr_v[p]);
            if (cs_v[p] && wr_v[p] && a < DEPTH) begin
                for (int b = 0; b < 4; b++)
                    if (be_v[p][b]) mem_m[a][b*8 +: 8] = wd_v[p][b*8 +: 8];
            end
        end
    endtask

    task automatic cycle();
        bit en;
        bit rdy;
        bit due;
        #1;
        en  = clken_r && !reset_req_r;
        rdy = (en_since >= DEPTH + 1);
        for (int d = 0; d < 2; d++) check("init_done", d, o_done[d], rdy);
        for (int k = 0; k < 4; k++) begin
            check("waitrequest", k, o_wait[k], !(rdy && en));
            due = en && (rb_cnt[k] > 0) && (rb_due[k][rb_head[k]] == en_idx);
            check("readdatavalid", k, o_valid[k], due);
            if (due) begin
                if (o_valid[k]) check("readdata", k, o_rdata[k], rb_data[k][rb_head[k]]);
                rb_head[k] = (rb_head[k] + 1) % 8;
                rb_cnt[k]--;
            end
        end
        if (en) begin
            if (rdy) model_accept();
            en_since++;
            en_idx++;
        end
        @(negedge clk);
    endtask

    task automatic idle_ports();
        for (int p = 0; p < 2; p++) begin
            cs_v[p] = 1'b0; rd_v[p] = 1'b0; wr_v[p] = 1'b0;
            addr_v[p] = '0; be_v[p] = '0; wd_v[p] = '0;
        end
    endtask

    task automatic rd_op(input int p, input logic [12:0] a);
        cs_v[p] = 1'b1; rd_v[p] = 1'b1; wr_v[p] = 1'b0; addr_v[p] = a;
    endtask

    task automatic wr_op(input int p, input logic [12:0] a, input logic [31:0] d,
                         input logic [3:0] be);
        cs_v[p] = 1'b1; rd_v[p] = 1'b0; wr_v[p] = 1'b1;
        addr_v[p] = a; wd_v[p] = d; be_v[p] = be;
    endtask

    task automatic run_idle(input int n);
        idle_ports();
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            check("valid_in_reset", k, o_valid[k], 1'b0);
            check("wait_in_reset", k, o_wait[k], 1'b1);
        end
        for (int d = 0; d < 2; d++) check("done_in_reset", d, o_done[d], 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset    = 1'b0;
        en_since = 0;
        for (int k = 0; k < 4; k++) begin
            rb_head[k] = 0;
            rb_cnt[k]  = 0;
        end
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    endtask

    initial begin
        idle_ports();
        clken_r     = 1'b1;
        reset_req_r = 1'b0;
        reset       = 1'b0;
        #1;
        apply_reset();

        // Clear sweep with a two-cycle clken gap, then every word must read zero.
        for (int i = 0; i < 22; i++) begin
            clken_r = !(i == 5 || i == 6);
            cycle();
        end
        clken_r = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            rd_op(0, 13'(i));
            rd_op(1, 13'(DEPTH - 1 - i));
            cycle();
        end
        run_idle(3);

        // Partial byte write seen by the other port.
        wr_op(0, 13'd3, 32'hDEADBEEF, 4'b0101); cycle(); idle_ports();
        rd_op(1, 13'd3); cycle();
        run_idle(3);

        // Cross-port read during a write returns the old word, then the new one.
        wr_op(0, 13'd5, 32'h22222222, 4'b1111); cycle(); idle_ports();
        wr_op(0, 13'd5, 32'h11111111, 4'b1111); rd_op(1, 13'd5); cycle(); idle_ports();
        rd_op(1, 13'd5); cycle();
        run_idle(3);

        // Both ports write the same word.
        wr_op(0, 13'd7, 32'h55555555, 4'b1111); cycle(); idle_ports();
        wr_op(0, 13'd7, 32'hAAAAAAAA, 4'b1100); wr_op(1, 13'd7, 32'h55555555, 4'b0110);
        cycle(); idle_ports();
        rd_op(0, 13'd7); rd_op(1, 13'd7); cycle();
        run_idle(3);

        // Back-to-back reads with a clken stall in the middle of the stream.
        for (int i = 0; i < 4; i++) begin
            wr_op(0, 13'(i), 32'h1000_0000 + 32'(i * 3 + 1), 4'b1111);
            cycle();
        end
        idle_ports();
        rd_op(0, 13'd0); cycle();
        rd_op(0, 13'd1); cycle();
        rd_op(0, 13'd2); clken_r = 1'b0; cycle(); cycle();
        clken_r = 1'b1; cycle();
        rd_op(0, 13'd3); cycle();
        run_idle(4);

        // Out-of-range accesses, and same-port read+write dropping the read.
        wr_op(0, 13'd5000, 32'hCAFEF00D, 4'b1111); cycle(); idle_ports();
        rd_op(0, 13'd5000); rd_op(1, 13'd8); cycle(); idle_ports();
        wr_op(1, 13'd9, 32'h0BADCAFE, 4'b1111); rd_v[1] = 1'b1; cycle(); idle_ports();
        rd_op(1, 13'd9); cycle();
        run_idle(3);

        // Randomized traffic with stalls.
        for (int i = 0; i < 300; i++) begin
            clken_r     = ($urandom_range(0, 7) != 0);
            reset_req_r = ($urandom_range(0, 9) == 0);
            for (int p = 0; p < 2; p++) begin
                cs_v[p]   = ($urandom_range(0, 3) != 0);
                rd_v[p]   = $urandom_range(0, 1) == 1;
                wr_v[p]   = ($urandom_range(0, 2) == 0);
                addr_v[p] = ($urandom_range(0, 11) == 0) ? 13'd5000 : 13'($urandom_range(0, 7));
                be_v[p]   = 4'($urandom_range(0, 15));
                wd_v[p]   = $urandom;
            end
            cycle();
        end
        clken_r     = 1'b1;
        reset_req_r = 1'b0;
        run_idle(4);

        // Reset with reads in flight: no strobes may follow.
        rd_op(0, 13'd1); rd_op(1, 13'd2); cycle(); idle_ports();
        apply_reset();
        run_idle(6);
        // Reset again mid-sweep: the sweep restarts from word 0.
        apply_reset();
        run_idle(20);
        for (int i = 0; i < DEPTH; i++) begin
            rd_op(0, 13'(i));
            rd_op(1, 13'(i));
            cycle();
        end
        run_idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
